// File: rtl/adder64b_sub.sv
// ---------------------------------------------------------------------------
// adder64b_sub
//
// Two's-complement adder/subtractor for the decode stage. It computes branch
// targets and compare arithmetic. The result is produced combinationally by a
// hierarchical carry-lookahead network with three levels:
//   - 4-bit CLA groups;
//   - 4-group blocks;
//   - a short chain across the blocks.
// A registered copy of the result is also provided for pipelined consumers.
//
// Ports
//   clk     in   1      rising-edge clock, drives only the registered outputs
//   rst_n   in   1      asynchronous active-low reset of the registered outputs
//   A       in   WIDTH  operand A
//   B       in   WIDTH  operand B
//   SUB     in   1      0: S = A + B, 1: S = A - B
//   S       out  WIDTH  combinational result, modulo 2^WIDTH
//   COUT    out  1      combinational carry out of the MSB (1 = no borrow on SUB)
//   OVF     out  1      combinational signed overflow
//   S_Q     out  WIDTH  S registered, 1-cycle latency
//   COUT_Q  out  1      COUT registered
//   OVF_Q   out  1      OVF registered
//
// WIDTH must be a multiple of 16 so that groups tile into 4-group blocks.
// ---------------------------------------------------------------------------
module adder64b_sub #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF,
    output logic [WIDTH-1:0] S_Q,
    output logic             COUT_Q,
    output logic             OVF_Q
);

    localparam int NG = WIDTH / 4;   // number of 4-bit groups
    localparam int NB = NG / 4;      // number of 4-group blocks

    logic [WIDTH-1:0] bx;            // B, inverted for subtraction
    logic [WIDTH-1:0] g;             // bit generate
    logic [WIDTH-1:0] p;             // bit propagate
    logic [WIDTH-1:0] c;             // carry into each bit

    logic [NG-1:0]    grp_g;         // group generate
    logic [NG-1:0]    grp_p;         // group propagate
    logic [NG-1:0]    grp_c;         // carry into each group

    logic [NB-1:0]    blk_g;         // block generate
    logic [NB-1:0]    blk_p;         // block propagate
    logic [NB:0]      blk_c;         // carry into each block; [NB] is carry out

    // Subtraction is A + ~B + 1. The +1 enters as the carry-in of the chain.
    assign bx = B ^ {WIDTH{SUB}};
    assign g  = A & bx;
    assign p  = A ^ bx;

    // Level 1: 4-bit CLA groups. Each group exports G/P and also derives its
    // internal bit carries from the carry delivered to the group.
    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            logic g0, g1, g2, g3, p0, p1, p2, p3, ci;
            assign g0 = g[4*gi];
            assign g1 = g[4*gi+1];
            assign g2 = g[4*gi+2];
            assign g3 = g[4*gi+3];
            assign p0 = p[4*gi];
            assign p1 = p[4*gi+1];
            assign p2 = p[4*gi+2];
            assign p3 = p[4*gi+3];
            assign ci = grp_c[gi];

            assign grp_g[gi] = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);
            assign grp_p[gi] = p3 & p2 & p1 & p0;

            assign c[4*gi]   = ci;
            assign c[4*gi+1] = g0 | (p0 & ci);
            assign c[4*gi+2] = g1 | (p1 & g0) | (p1 & p0 & ci);
            assign c[4*gi+3] = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & ci);
        end
    endgenerate

    // Level 2: lookahead over four groups. It produces block G/P and the carry
    // into each group from the carry delivered to the block.
    generate
        for (gi = 0; gi < NB; gi++) begin : g_blk
            logic g0, g1, g2, g3, p0, p1, p2, p3, ci;
            assign g0 = grp_g[4*gi];
            assign g1 = grp_g[4*gi+1];
            assign g2 = grp_g[4*gi+2];
            assign g3 = grp_g[4*gi+3];
            assign p0 = grp_p[4*gi];
            assign p1 = grp_p[4*gi+1];
            assign p2 = grp_p[4*gi+2];
            assign p3 = grp_p[4*gi+3];
            assign ci = blk_c[gi];

            assign blk_g[gi] = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);
            assign blk_p[gi] = p3 & p2 & p1 & p0;

            assign grp_c[4*gi]   = ci;
            assign grp_c[4*gi+1] = g0 | (p0 & ci);
            assign grp_c[4*gi+2] = g1 | (p1 & g0) | (p1 & p0 & ci);
            assign grp_c[4*gi+3] = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & ci);
        end
    endgenerate

    // Level 3: carry across the blocks. At WIDTH=64 there are only four
    // blocks, so a short G/P chain is enough here.
    assign blk_c[0] = SUB;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_top
            assign blk_c[gi+1] = blk_g[gi] | (blk_p[gi] & blk_c[gi]);
        end
    endgenerate

    assign S    = p ^ c;
    assign COUT = blk_c[NB];
    // Signed overflow: the carry into the MSB disagrees with the carry out of it.
    assign OVF  = c[WIDTH-1] ^ blk_c[NB];

    // Pipelined copy. It samples every cycle and has no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_Q    <= '0;
            COUT_Q <= 1'b0;
            OVF_Q  <= 1'b0;
        end else begin
            S_Q    <= S;
            COUT_Q <= COUT;
            OVF_Q  <= OVF;
        end
    end

endmodule

// File: tb/tb_adder64b_sub.sv
// ---------------------------------------------------------------------------
// tb_adder64b_sub
//
// Self-checking bench for adder64b_sub.
//   - Directed vectors are compared against literal expected values.
//   - Random vectors are compared against a behavioural model. The model forms
//     the exact 65-bit sum A + (B ^ SUB) + SUB and derives overflow from the
//     operand and result signs.
//   - Registered outputs are checked one cycle after each input change, and
//     again around reset assertion and release.
// ---------------------------------------------------------------------------
module tb_adder64b_sub;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub_in;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic [W-1:0] s_q;
    logic         cout_q;
    logic         ovf_q;

    int n_vec;
    int n_err;

    adder64b_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a_in),
        .B      (b_in),
        .SUB    (sub_in),
        .S      (s),
        .COUT   (cout),
        .OVF    (ovf),
        .S_Q    (s_q),
        .COUT_Q (cout_q),
        .OVF_Q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: exact wide sum, overflow from operand/result signs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        logic [W:0]   wide;
        logic [W-1:0] bx;
        bx   = sb ? ~b : b;
        wide = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sb};
        es   = wide[W-1:0];
        ec   = wide[W];
        eo   = (a[W-1] == bx[W-1]) && (es[W-1] != a[W-1]);
    endtask

    // Apply one transaction.
    //   - Inputs are driven after a falling edge.
    //   - Combinational outputs are checked 1 ns later.
    //   - Registered outputs are checked 1 ns after the following rising edge.
    task automatic apply(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sb, input logic [W-1:0] es, input logic ec, input logic eo,
                         input bit verbose);
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        sub_in = sb;
        #1;
        check_val({name, ".S"},    s,            es);
        check_val({name, ".COUT"}, {63'd0, cout}, {63'd0, ec});
        check_val({name, ".OVF"},  {63'd0, ovf},  {63'd0, eo});
        @(posedge clk);
        #1;
        check_val({name, ".S_Q"},    s_q,             es);
        check_val({name, ".COUT_Q"}, {63'd0, cout_q}, {63'd0, ec});
        check_val({name, ".OVF_Q"},  {63'd0, ovf_q},  {63'd0, eo});
        if (verbose)
            $display("%-10s A=%h B=%h SUB=%0d -> S=%h COUT=%0d OVF=%0d", name, a, b, sb, s, cout, ovf);
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rs, ec, eo;
        n_vec  = 0;
        n_err  = 0;
        a_in   = '0;
        b_in   = '0;
        sub_in = 1'b0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;

        // While held in reset: registers stay 0, combinational path still works.
        @(negedge clk);
        a_in = 64'd5; b_in = 64'd4; sub_in = 1'b0;
        @(posedge clk); #1;
        check_val("rst.S_Q",    s_q,              64'd0);
        check_val("rst.COUT_Q", {63'd0, cout_q},  64'd0);
        check_val("rst.OVF_Q",  {63'd0, ovf_q},   64'd0);
        check_val("rst.S",      s,                64'd9);
        $display("reset      S_Q=%h S=%h", s_q, s);

        // Release between edges: still 0 until the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel.S_Q", s_q, 64'd0);
        @(posedge clk); #1;
        check_val("rel.S_Q1", s_q, 64'd9);
        $display("release    S_Q=%h", s_q);

        // Directed vectors with literal expected values.
        apply("add",     64'd5,   64'd4,   1'b0, 64'd9,                   1'b0, 1'b0, 1'b1);
        apply("sadd",    -64'sd11, 64'd9,  1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        apply("ssub",    -64'sd110, -64'sd33, 1'b1, -64'sd77,             1'b0, 1'b0, 1'b1);
        apply("sub",     64'd53,  64'd47,  1'b1, 64'd6,                   1'b1, 1'b0, 1'b1);
        apply("sub0",    64'd0,   64'd0,   1'b1, 64'd0,                   1'b1, 1'b0, 1'b1);
        apply("maxpos",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        apply("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0,     1'b1, 1'b0, 1'b1);
        apply("minneg",  64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);

        // Mid-operation reset clears the registers immediately; S stays valid.
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst.S_Q",    s_q,             64'd0);
        check_val("midrst.COUT_Q", {63'd0, cout_q}, 64'd0);
        check_val("midrst.OVF_Q",  {63'd0, ovf_q},  64'd0);
        check_val("midrst.S",      s,               64'h7FFF_FFFF_FFFF_FFFF);
        $display("midreset   S_Q=%h S=%h", s_q, s);
        @(negedge clk);
        rst_n = 1'b1;

        // Random vectors against the model. Some operands are biased toward
        // all-ones / one / zero so that full-length carry chains occur often.
        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: begin ra = '1; rb = 64'd1; end
                1: ra = '1;
                2: rb = rs ? '0 : 64'd1;
                3: rb = ra;
                default: ;
            endcase
            model(ra, rb, rs, es, ec, eo);
            apply($sformatf("rnd%0d", i), ra, rb, rs, es, ec, eo, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
